// File: rtl/ikaopll_bus_write_receiver.sv
// ikaopll_bus_write_receiver: synchronises the CPU write bus, latches address/data phases,
// enforces post-write wait times and emits one phiM-aligned register-file write per data phase.
`timescale 1ns/1ps
module ikaopll_bus_write_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WAIT   = 12,
  parameter int DATA_WAIT   = 84
) (
  input  logic       i_XIN_EMUCLK,
  input  logic       i_IC_n,
  input  logic       i_phiM_PCEN_n,
  input  logic       i_CS_n,
  input  logic       i_WR_n,
  input  logic       i_A0,
  input  logic [7:0] i_D,
  output logic [7:0] o_REG_ADDR,
  output logic [7:0] o_REG_DATA,
  output logic       o_REG_WR,
  output logic       o_ADDR_VALID,
  output logic       o_BUSY,
  output logic       o_DROP
);
  localparam int MW = ADDR_WAIT > DATA_WAIT ? ADDR_WAIT : DATA_WAIT;
  localparam int CW = $clog2(MW + 1);
  typedef enum logic [1:0] {IDLE, PEND, WAIT} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] cs_sr, wr_sr, a0_sr;
  logic [SYNC_STAGES-1:0][7:0] d_sr;
  logic strb, strb_q, commit, a0_h, valid_n;
  logic [7:0] d_h, addr_n, data_n;
  logic [CW-1:0] cnt, cnt_n;
  assign strb = ~cs_sr[SYNC_STAGES-1] & ~wr_sr[SYNC_STAGES-1];
  assign commit = strb_q & ~strb;
  assign o_BUSY = state != IDLE;
  assign o_REG_WR = state == PEND && !i_phiM_PCEN_n;
  assign o_DROP = commit & o_BUSY;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    addr_n = o_REG_ADDR;
    data_n = o_REG_DATA;
    valid_n = o_ADDR_VALID;
    case (state)
      IDLE:
        if (commit && !a0_h) begin
          addr_n = d_h;
          valid_n = 1'b1;
          cnt_n = CW'(ADDR_WAIT);
          state_n = WAIT;
        end else if (commit && o_ADDR_VALID) begin
          data_n = d_h;
          state_n = PEND;
        end
      PEND:
        if (!i_phiM_PCEN_n) begin
          cnt_n = CW'(DATA_WAIT);
          state_n = WAIT;
        end
      WAIT:
        if (!i_phiM_PCEN_n) begin
          cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
          state_n = cnt <= CW'(1) ? IDLE : WAIT;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_XIN_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      cs_sr <= '1;
      wr_sr <= '1;
      a0_sr <= '0;
      d_sr <= '0;
      strb_q <= 1'b0;
      a0_h <= 1'b0;
      d_h <= '0;
      state <= IDLE;
      cnt <= '0;
      o_REG_ADDR <= '0;
      o_REG_DATA <= '0;
      o_ADDR_VALID <= 1'b0;
    end else begin
      cs_sr <= {cs_sr[SYNC_STAGES-2:0], i_CS_n};
      wr_sr <= {wr_sr[SYNC_STAGES-2:0], i_WR_n};
      a0_sr <= {a0_sr[SYNC_STAGES-2:0], i_A0};
      d_sr <= {d_sr[SYNC_STAGES-2:0], i_D};
      strb_q <= strb;
      // hold keeps the last phase value seen while the strobe was active
      if (strb) begin
        a0_h <= a0_sr[SYNC_STAGES-1];
        d_h <= d_sr[SYNC_STAGES-1];
      end
      state <= state_n;
      cnt <= cnt_n;
      o_REG_ADDR <= addr_n;
      o_REG_DATA <= data_n;
      o_ADDR_VALID <= valid_n;
    end
  end
endmodule

// File: tb/tb_ikaopll_bus_write_receiver.sv
// tb_ikaopll_bus_write_receiver: directed and random bus writes checked against a transaction-level model.
`timescale 1ns/1ps
module tb_ikaopll_bus_write_receiver;
  logic i_XIN_EMUCLK = 0, i_IC_n = 0, i_phiM_PCEN_n = 1, i_CS_n = 1, i_WR_n = 1, i_A0 = 0;
  logic [7:0] i_D = 0;
  logic [7:0] o_REG_ADDR, o_REG_DATA;
  logic o_REG_WR, o_ADDR_VALID, o_BUSY, o_DROP;
  int checks = 0, errors = 0;
  int wr_cnt = 0, drop_cnt = 0, tick_cnt = 0, wr_bad = 0;
  logic [7:0] wr_addr = 0, wr_data = 0;
  bit pcen_hold = 0;
  bit m_valid = 0, prev_long = 1, prev_acc = 0;
  logic [7:0] m_addr = 0, m_data = 0;
  int ep_base = 0, ep_exp = 0;

  ikaopll_bus_write_receiver dut (
    .i_XIN_EMUCLK(i_XIN_EMUCLK), .i_IC_n(i_IC_n), .i_phiM_PCEN_n(i_phiM_PCEN_n),
    .i_CS_n(i_CS_n), .i_WR_n(i_WR_n), .i_A0(i_A0), .i_D(i_D),
    .o_REG_ADDR(o_REG_ADDR), .o_REG_DATA(o_REG_DATA), .o_REG_WR(o_REG_WR),
    .o_ADDR_VALID(o_ADDR_VALID), .o_BUSY(o_BUSY), .o_DROP(o_DROP)
  );

  always #5 i_XIN_EMUCLK = ~i_XIN_EMUCLK;

  initial begin
    int ph = 0;
    forever begin
      @(posedge i_XIN_EMUCLK);
      #1;
      ph = (ph + 1) % 4;
      i_phiM_PCEN_n = pcen_hold || ph != 0;
    end
  end

  always @(negedge i_XIN_EMUCLK) begin
    if (o_REG_WR) begin
      wr_cnt++;
      wr_addr = o_REG_ADDR;
      wr_data = o_REG_DATA;
      if (i_phiM_PCEN_n) wr_bad++;
    end
    if (o_DROP) drop_cnt++;
    if (o_BUSY && !i_phiM_PCEN_n) tick_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic strobe(input logic a0, input logic [7:0] d);
    @(posedge i_XIN_EMUCLK);
    #1;
    i_A0 = a0;
    i_D = 8'($urandom);
    i_CS_n = 0;
    i_WR_n = 0;
    @(posedge i_XIN_EMUCLK);
    #1;
    i_D = d;
    repeat (2) @(posedge i_XIN_EMUCLK);
    #1;
    if ($urandom_range(0, 1) == 1) begin
      i_CS_n = 1;
      @(posedge i_XIN_EMUCLK);
      #1;
      i_WR_n = 1;
    end else begin
      i_WR_n = 1;
      i_CS_n = 1;
    end
    i_D = 8'($urandom);
    i_A0 = 1'($urandom);
  endtask

  task automatic do_write(input logic a0, input logic [7:0] d, input bit long_in);
    bit drop, acc, long_after;
    int w0, d0;
    drop = !prev_long && prev_acc;
    acc = !drop && (!a0 || m_valid);
    long_after = long_in || drop;
    if (prev_long) begin
      ep_base = tick_cnt;
      ep_exp = 0;
    end
    if (acc && !a0) begin
      m_addr = d;
      m_valid = 1;
      ep_exp = 12;
    end
    if (acc && a0) begin
      m_data = d;
      ep_exp = 85;
    end
    w0 = wr_cnt;
    d0 = drop_cnt;
    strobe(a0, d);
    repeat (12) @(posedge i_XIN_EMUCLK);
    @(negedge i_XIN_EMUCLK);
    check("wr_count", wr_cnt - w0, (acc && a0) ? 1 : 0);
    check("drop_count", drop_cnt - d0, drop);
    if (acc && a0) begin
      check("wr_addr", wr_addr, m_addr);
      check("wr_data", wr_data, m_data);
    end
    check("addr_valid", o_ADDR_VALID, m_valid);
    check("reg_addr", o_REG_ADDR, m_addr);
    check("reg_data", o_REG_DATA, m_data);
    check("busy", o_BUSY, acc || drop);
    if (long_after) begin
      repeat (400) @(negedge i_XIN_EMUCLK);
      check("idle_busy", o_BUSY, 0);
      check("busy_ticks", tick_cnt - ep_base, ep_exp);
    end
    prev_acc = acc;
    prev_long = long_after;
  endtask

  initial begin
    int w0;
    repeat (4) @(negedge i_XIN_EMUCLK);
    check("rst_addr", o_REG_ADDR, 0);
    check("rst_data", o_REG_DATA, 0);
    check("rst_wr", o_REG_WR, 0);
    check("rst_valid", o_ADDR_VALID, 0);
    check("rst_busy", o_BUSY, 0);
    check("rst_drop", o_DROP, 0);
    @(posedge i_XIN_EMUCLK);
    #1;
    i_IC_n = 1;
    repeat (6) @(negedge i_XIN_EMUCLK);
    check("post_rst_busy", o_BUSY, 0);
    do_write(1, 8'h55, 1);
    do_write(0, 8'h10, 1);
    do_write(1, 8'hAC, 1);
    do_write(0, 8'h21, 0);
    do_write(1, 8'h18, 1);
    do_write(0, 8'h20, 1);
    do_write(1, 8'h18, 1);
    do_write(1, 8'h02, 1);
    pcen_hold = 1;
    w0 = wr_cnt;
    strobe(1, 8'h99);
    repeat (12) @(posedge i_XIN_EMUCLK);
    @(negedge i_XIN_EMUCLK);
    check("pend_busy", o_BUSY, 1);
    check("pend_no_wr", wr_cnt - w0, 0);
    i_IC_n = 0;
    #1;
    check("abort_addr", o_REG_ADDR, 0);
    check("abort_data", o_REG_DATA, 0);
    check("abort_valid", o_ADDR_VALID, 0);
    check("abort_busy", o_BUSY, 0);
    check("abort_wr", o_REG_WR, 0);
    repeat (3) @(posedge i_XIN_EMUCLK);
    #1;
    i_IC_n = 1;
    pcen_hold = 0;
    repeat (30) @(negedge i_XIN_EMUCLK);
    check("abort_no_wr", wr_cnt - w0, 0);
    check("abort_idle", o_BUSY, 0);
    m_valid = 0;
    m_addr = 0;
    m_data = 0;
    prev_long = 1;
    prev_acc = 0;
    do_write(0, 8'h44, 1);
    do_write(1, 8'h66, 1);
    for (int i = 0; i < 25; i++)
      do_write(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2) != 0);
    check("wr_on_pcen", wr_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
